// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: two read ports, one writeback port, issue port and hazard/stall status.
// The master side is the CPU pipeline (ID/WB); the slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4
);
  logic [ASIZE-1:0] raddr1;
  logic [ASIZE-1:0] raddr2;
  logic [DSIZE-1:0] rdata1;
  logic [DSIZE-1:0] rdata2;
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;
  logic             iss_valid;
  logic             iss_wen;
  logic [ASIZE-1:0] iss_waddr;
  logic             hazard1;
  logic             hazard2;
  logic             iss_full;
  logic             stall;

  modport master (
    output raddr1, raddr2, wen, waddr, wdata, iss_valid, iss_wen, iss_waddr,
    input  rdata1, rdata2, hazard1, hazard2, iss_full, stall
  );

  modport slave (
    input  raddr1, raddr2, wen, waddr, wdata, iss_valid, iss_wen, iss_waddr,
    output rdata1, rdata2, hazard1, hazard2, iss_full, stall
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass on both read ports and a per-register
// pending-write counter that flags read-after-write hazards and issue saturation.
module regfile_scoreboard #(
  parameter int DSIZE   = 16,
  parameter int ASIZE   = 4,
  parameter int CNTW    = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                clk,
  input  logic                rst,
  regfile_scoreboard_if.slave bus
);
  localparam int NREG = 2 ** ASIZE;
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [DSIZE-1:0] value_view [NREG];
  logic [CNTW-1:0]  cnt_view   [NREG];

  logic             w_legal;
  logic             iss_legal;
  logic [ASIZE-1:0] raddr  [2];
  logic [DSIZE-1:0] rdata  [2];
  logic             hazard [2];

  // Register 0 is hard-wired to zero only when ZERO_R0 is set.
  assign w_legal   = !((ZERO_R0 != 0) && (bus.waddr == '0));
  assign iss_legal = !((ZERO_R0 != 0) && (bus.iss_waddr == '0));

  assign raddr[0]    = bus.raddr1;
  assign raddr[1]    = bus.raddr2;
  assign bus.rdata1  = rdata[0];
  assign bus.rdata2  = rdata[1];
  assign bus.hazard1 = hazard[0];
  assign bus.hazard2 = hazard[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic zero_port;
      logic retiring;
      assign zero_port = (ZERO_R0 != 0) && (raddr[gi] == '0);
      assign retiring  = bus.wen && w_legal && (bus.waddr == raddr[gi]);

      always_comb begin
        rdata[gi]  = value_view[raddr[gi]];
        hazard[gi] = 1'b0;
        if (retiring)
          rdata[gi] = bus.wdata;
        // The last pending write retiring now is covered by the bypass path.
        if ((cnt_view[raddr[gi]] != '0) && !(retiring && (cnt_view[raddr[gi]] == CNT_ONE)))
          hazard[gi] = 1'b1;
        if (zero_port) begin
          rdata[gi]  = '0;
          hazard[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // A retire to the issuing destination frees a slot in the same cycle.
  assign bus.iss_full = (cnt_view[bus.iss_waddr] == CNT_MAX) &&
                        !(bus.wen && (bus.waddr == bus.iss_waddr));
  assign bus.stall    = hazard[0] | hazard[1] | (bus.iss_wen & bus.iss_full);

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DSIZE-1:0] value_reg;
      logic [CNTW-1:0]  cnt_reg;
      logic             wr_hit;
      logic             inc;
      logic             dec;

      assign wr_hit = bus.wen && w_legal && (bus.waddr == ASIZE'(gi));
      assign inc    = bus.iss_valid && bus.iss_wen && !bus.stall && iss_legal &&
                      (bus.iss_waddr == ASIZE'(gi));
      assign dec    = wr_hit && (cnt_reg != '0);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          value_reg <= '0;
          cnt_reg   <= '0;
        end else begin
          if (wr_hit)
            value_reg <= bus.wdata;
          if (inc && !dec)
            cnt_reg <= cnt_reg + CNT_ONE;
          else if (dec && !inc)
            cnt_reg <= cnt_reg - CNT_ONE;
        end
      end

      assign value_view[gi] = value_reg;
      assign cnt_view[gi]   = cnt_reg;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, RAW hazards, double pending, saturation,
// mid-run reset and a second instance with register 0 hard-wired to zero.
module tb_regfile_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_scoreboard_if #(.DSIZE(16), .ASIZE(4)) bus_a ();
  regfile_scoreboard_if #(.DSIZE(16), .ASIZE(4)) bus_b ();

  regfile_scoreboard #(.DSIZE(16), .ASIZE(4), .CNTW(2), .ZERO_R0(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  regfile_scoreboard #(.DSIZE(16), .ASIZE(4), .CNTW(2), .ZERO_R0(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.raddr1 = '0; bus_a.raddr2 = '0;
    bus_a.wen = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0;
    bus_a.iss_valid = 1'b0; bus_a.iss_wen = 1'b0; bus_a.iss_waddr = '0;
  endtask

  task automatic idle_b();
    bus_b.raddr1 = '0; bus_b.raddr2 = '0;
    bus_b.wen = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0;
    bus_b.iss_valid = 1'b0; bus_b.iss_wen = 1'b0; bus_b.iss_waddr = '0;
  endtask

  task automatic issue_a(input logic [3:0] r);
    bus_a.iss_valid = 1'b1; bus_a.iss_wen = 1'b1; bus_a.iss_waddr = r;
    #1;
    check("issue_no_stall", 32'(bus_a.stall), 32'd0);
    step();
    bus_a.iss_valid = 1'b0; bus_a.iss_wen = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_a();
    idle_b();
    #2;
    check("rst_rdata1", 32'(bus_a.rdata1), 32'd0);
    check("rst_hazard1", 32'(bus_a.hazard1), 32'd0);
    check("rst_stall", 32'(bus_a.stall), 32'd0);
    check("rst_iss_full", 32'(bus_a.iss_full), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Bypass: write r5 while reading it
    bus_a.raddr1 = 4'd5;
    #1;
    check("pre_write_r5", 32'(bus_a.rdata1), 32'd0);
    bus_a.wen = 1'b1; bus_a.waddr = 4'd5; bus_a.wdata = 16'h00A5;
    #1;
    check("bypass_rdata1", 32'(bus_a.rdata1), 32'h00A5);
    check("bypass_no_hazard", 32'(bus_a.hazard1), 32'd0);
    step();
    bus_a.wen = 1'b0;
    #1;
    check("stored_r5", 32'(bus_a.rdata1), 32'h00A5);

    // RAW on r2; issuing and reading r2 in one cycle does not self-hazard
    bus_a.raddr1 = 4'd2; bus_a.raddr2 = 4'd0;
    issue_a(4'd2);
    bus_a.raddr1 = 4'd0; bus_a.raddr2 = 4'd2;
    #1;
    check("raw_hazard2", 32'(bus_a.hazard2), 32'd1);
    check("raw_stall", 32'(bus_a.stall), 32'd1);
    bus_a.wen = 1'b1; bus_a.waddr = 4'd2; bus_a.wdata = 16'd7;
    #1;
    check("raw_retire_hazard2", 32'(bus_a.hazard2), 32'd0);
    check("raw_retire_rdata2", 32'(bus_a.rdata2), 32'd7);
    check("raw_retire_stall", 32'(bus_a.stall), 32'd0);
    step();
    bus_a.wen = 1'b0;
    #1;
    check("raw_cleared_hazard2", 32'(bus_a.hazard2), 32'd0);
    check("raw_stored_r2", 32'(bus_a.rdata2), 32'd7);

    // Double pending on r4
    bus_a.raddr1 = 4'd0; bus_a.raddr2 = 4'd0;
    issue_a(4'd4);
    issue_a(4'd4);
    bus_a.raddr1 = 4'd4;
    #1;
    check("dbl_hazard1", 32'(bus_a.hazard1), 32'd1);
    bus_a.wen = 1'b1; bus_a.waddr = 4'd4; bus_a.wdata = 16'h1111;
    #1;
    check("dbl_first_retire_hazard1", 32'(bus_a.hazard1), 32'd1);
    step();
    bus_a.wen = 1'b0;
    #1;
    check("dbl_after_first_hazard1", 32'(bus_a.hazard1), 32'd1);
    bus_a.wen = 1'b1; bus_a.wdata = 16'h2222;
    #1;
    check("dbl_second_retire_hazard1", 32'(bus_a.hazard1), 32'd0);
    check("dbl_second_retire_rdata1", 32'(bus_a.rdata1), 32'h2222);
    step();
    bus_a.wen = 1'b0;
    #1;
    check("dbl_done_hazard1", 32'(bus_a.hazard1), 32'd0);
    check("dbl_stored_r4", 32'(bus_a.rdata1), 32'h2222);

    // Saturation on r6 (max 3 pending)
    bus_a.raddr1 = 4'd1; bus_a.raddr2 = 4'd1;
    issue_a(4'd6);
    issue_a(4'd6);
    issue_a(4'd6);
    bus_a.iss_valid = 1'b1; bus_a.iss_wen = 1'b1; bus_a.iss_waddr = 4'd6;
    #1;
    check("sat_iss_full", 32'(bus_a.iss_full), 32'd1);
    check("sat_stall", 32'(bus_a.stall), 32'd1);
    step();
    check("sat_still_full", 32'(bus_a.iss_full), 32'd1);
    bus_a.wen = 1'b1; bus_a.waddr = 4'd6; bus_a.wdata = 16'h0066;
    #1;
    check("sat_retire_iss_full", 32'(bus_a.iss_full), 32'd0);
    check("sat_retire_stall", 32'(bus_a.stall), 32'd0);
    step();
    bus_a.wen = 1'b0;
    #1;
    check("sat_cnt_stays3", 32'(bus_a.iss_full), 32'd1);
    bus_a.iss_wen = 1'b0;
    #1;
    check("sat_no_wen_no_stall", 32'(bus_a.stall), 32'd0);
    bus_a.iss_valid = 1'b0;

    // Untracked write to r3, then two pending writes, then reset mid-run
    bus_a.raddr1 = 4'd3;
    bus_a.wen = 1'b1; bus_a.waddr = 4'd3; bus_a.wdata = 16'hBEEF;
    step();
    bus_a.wen = 1'b0;
    #1;
    check("untracked_r3", 32'(bus_a.rdata1), 32'hBEEF);
    check("untracked_no_hazard", 32'(bus_a.hazard1), 32'd0);
    bus_a.raddr1 = 4'd0;
    issue_a(4'd3);
    issue_a(4'd3);
    bus_a.raddr1 = 4'd3;
    #1;
    check("pre_rst_hazard1", 32'(bus_a.hazard1), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_rdata1", 32'(bus_a.rdata1), 32'd0);
    check("midrst_hazard1", 32'(bus_a.hazard1), 32'd0);
    step();
    rst = 1'b1;
    bus_a.iss_wen = 1'b1; bus_a.iss_waddr = 4'd6;
    #1;
    check("postrst_rdata1", 32'(bus_a.rdata1), 32'd0);
    check("postrst_hazard1", 32'(bus_a.hazard1), 32'd0);
    check("postrst_iss_full_r6", 32'(bus_a.iss_full), 32'd0);
    check("postrst_stall", 32'(bus_a.stall), 32'd0);
    idle_a();

    // Register 0 hard-wired to zero on the second instance
    bus_b.raddr1 = 4'd0;
    bus_b.wen = 1'b1; bus_b.waddr = 4'd0; bus_b.wdata = 16'hFFFF;
    bus_b.iss_valid = 1'b1; bus_b.iss_wen = 1'b1; bus_b.iss_waddr = 4'd0;
    #1;
    check("r0_bypass_blocked", 32'(bus_b.rdata1), 32'd0);
    check("r0_hazard1", 32'(bus_b.hazard1), 32'd0);
    check("r0_stall", 32'(bus_b.stall), 32'd0);
    step();
    idle_b();
    #1;
    check("r0_read_zero", 32'(bus_b.rdata1), 32'd0);
    check("r0_not_pending", 32'(bus_b.hazard1), 32'd0);
    bus_b.iss_valid = 1'b1; bus_b.iss_wen = 1'b1; bus_b.iss_waddr = 4'd1;
    step();
    idle_b();
    bus_b.raddr1 = 4'd1;
    #1;
    check("r1_pending_zr0", 32'(bus_b.hazard1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
